regfile_sb: RTL and testbench

Parametrised integer register file for the RISC-V core. It has NRD combinational read ports, one byte-enabled write port, and optional write-to-read bypass. A per-register busy scoreboard is set when an instruction issues and cleared when that instruction writes back, so the pipeline can detect RAW hazards. Sits between decode (read/issue) and writeback (write).

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_sb.sv | 86 ++++++++
 tb/tb_regfile_sb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the integer register file: default widths, the
// register-address type, the hardwired zero register index and the byte-merge
// helper used by both the write path and the read bypass.
package riscv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Widest datapath the merge helper supports; narrower users zero-extend.
  localparam int XLEN_MAX  = 64;
  localparam int BE_MAX    = XLEN_MAX / 8;

  typedef logic [AW_DEF-1:0] regaddr_t;

  localparam int REG_ZERO = 0;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [XLEN_MAX-1:0] merge_be(input logic [XLEN_MAX-1:0] old_val,
                                                   input logic [XLEN_MAX-1:0] new_val,
                                                   input logic [BE_MAX-1:0]   be);
    logic [XLEN_MAX-1:0] res;
    res = old_val;
    for (int b = 0; b < BE_MAX; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. Issue sets a bit, writeback clears it, flush
// clears everything; busy_cnt is the registered popcount of the busy vector.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // Next busy vector: flush beats everything, and a new issue beats a same-cycle writeback.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
      if (iss_en) busy_nxt[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
  end

  // Popcount of the next busy vector so busy_cnt moves in the same cycle as the bits.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one byte-enabled
// write port, optional same-cycle write-to-read bypass and a busy scoreboard
// for RAW hazard detection between decode and writeback.
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int NBE     = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NBE-1:0]    wr_be,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_zero;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_val,
                                            input logic [XLEN-1:0] new_val,
                                            input logic [NBE-1:0]  be);
    return XLEN'(merge_be(XLEN_MAX'(old_val), XLEN_MAX'(new_val), BE_MAX'(be)));
  endfunction

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == AW'(REG_ZERO));

  // Storage array: byte-merged write; the hardwired zero register is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_en && !wr_zero) begin
      regs[wr_addr] <= merge(regs[wr_addr], wr_data, wr_be);
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   a;
    logic            is_zero;
    logic            hit;
    logic [XLEN-1:0] stored;

    assign a       = rd_addr[gi*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (a == AW'(REG_ZERO));
    assign stored  = is_zero ? '0 : regs[a];
    // Bypass is held off during reset so the outputs show the cleared state.
    assign hit     = (BYPASS != 0) && rst_n && wr_en && (wr_addr == a) && !is_zero;

    // Read mux: forward the merged write data and the cleared busy bit on a bypass hit,
    // unless the same register is being re-issued this cycle.
    always_comb begin
      rd_data[gi*XLEN +: XLEN] = hit ? merge(stored, wr_data, wr_be) : stored;
      rd_busy[gi]              = (hit && !(iss_en && iss_addr == a)) ? 1'b0 : busy[a];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a driver applies directed then random
// stimulus and queues the outputs predicted by an array-based model; a monitor
// pops each prediction and compares it with the DUT outputs mid-cycle.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;
  localparam int BYPASS = 1;
  localparam int ZERO_REG = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [XLEN-1:0]   wr_data = '0;
  logic [3:0]        wr_be = '0;
  logic              iss_en = 1'b0;
  logic [AW-1:0]     iss_addr = '0;
  logic              flush = 1'b0;
  logic [AW:0]       busy_cnt;
  logic [AW-1:0]     raddr [NRD];

  assign rd_addr = {raddr[1], raddr[0]};

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic [AW:0]         cnt;
    int                  tag;
  } exp_t;

  exp_t q[$];
  event smp;
  int   checks = 0;
  int   errors = 0;
  int   tagn = 0;

  // Reference model: architectural contents and the set of busy registers.
  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];

  function automatic logic [XLEN-1:0] bytes_over(input logic [XLEN-1:0] o, input logic [XLEN-1:0] n,
                                                 input logic [3:0] be);
    logic [XLEN-1:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   n;
    e.data = '0; e.busy = '0; n = 0;
    for (int r = 0; r < NREGS; r++) if (mbusy[r]) n++;
    e.cnt = rst_n ? (AW+1)'(n) : '0;
    for (int i = 0; i < NRD; i++) begin
      int  a;
      bit  zero, fwd;
      logic [XLEN-1:0] v;
      a    = int'(raddr[i]);
      zero = (ZERO_REG != 0) && (a == 0);
      v    = zero ? '0 : mregs[a];
      fwd  = (BYPASS != 0) && rst_n && wr_en && (int'(wr_addr) == a) && !zero;
      if (!rst_n) v = '0;
      e.data[i*XLEN +: XLEN] = fwd ? bytes_over(v, wr_data, wr_be) : v;
      e.busy[i] = (fwd && !(iss_en && int'(iss_addr) == a)) ? 1'b0 : (rst_n && mbusy[a]);
    end
    e.tag = tagn;
    return e;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mregs[r] = '0;
      mbusy[r] = 0;
    end
  endtask

  // Architectural effect of one clock edge with the currently applied inputs.
  task automatic model_edge();
    if (wr_en && !(ZERO_REG != 0 && wr_addr == 0))
      mregs[wr_addr] = bytes_over(mregs[wr_addr], wr_data, wr_be);
    if (flush) begin
      for (int r = 0; r < NREGS; r++) mbusy[r] = 0;
    end else begin
      if (wr_en) mbusy[wr_addr] = 0;
      if (iss_en && !(ZERO_REG != 0 && iss_addr == 0)) mbusy[iss_addr] = 1;
    end
  endtask

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the predicted outputs.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic [3:0] be, input logic ie, input logic [AW-1:0] ia,
                      input logic fl, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    iss_en = ie; iss_addr = ia; flush = fl;
    raddr[0] = r0; raddr[1] = r1;
    #1;
    tagn++;
    q.push_back(predict());
    -> smp;
    #0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                     input logic [3:0] be, input logic ie, input logic [AW-1:0] ia,
                     input logic fl, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    step(we, wa, wd, be, ie, ia, fl, r0, r1);
    tick();
  endtask

  // Monitor: compare every queued prediction against the live DUT outputs.
  initial begin
    forever begin
      @(smp);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (rd_data !== e.data) begin
          errors++;
          $display("FAIL rd_data #%0d: got %h, expected %h", e.tag, rd_data, e.data);
        end
        checks++;
        if (rd_busy !== e.busy) begin
          errors++;
          $display("FAIL rd_busy #%0d: got %b, expected %b", e.tag, rd_busy, e.busy);
        end
        checks++;
        if (busy_cnt !== e.cnt) begin
          errors++;
          $display("FAIL busy_cnt #%0d: got %0d, expected %0d", e.tag, busy_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    raddr[0] = '0; raddr[1] = '0;
    model_reset();
    #12 rst_n = 1'b1;

    // Reset state on two ports.
    step(0, 0, 0, 0, 0, 0, 0, 5, 31);
    ck("reset_data", 64'(rd_data), 64'h0);
    ck("reset_busy", 64'(rd_busy), 64'h0);
    ck("reset_cnt", 64'(busy_cnt), 64'h0);
    tick();

    // Byte-enabled writes and the hardwired zero register.
    cyc(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h000000AA, 4'h1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 3, 0);
    ck("byte_merge", 64'(rd_data[31:0]), 64'hDEADBEAA);
    tick();
    cyc(1, 0, 32'h1234, 4'hF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3);
    ck("x0_zero", 64'(rd_data[31:0]), 64'h0);
    tick();

    // Same-cycle bypass.
    step(1, 7, 32'h55, 4'hF, 0, 0, 0, 7, 0);
    ck("bypass", 64'(rd_data[31:0]), 64'h55);
    tick();

    // Issue then writeback of x4, then simultaneous issue and write.
    cyc(0, 0, 0, 0, 1, 4, 0, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 4, 0);
    ck("iss_busy", 64'(rd_busy[0]), 64'h1);
    ck("iss_cnt", 64'(busy_cnt), 64'h1);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 4, 0);
    cyc(1, 4, 32'h44, 4'hF, 0, 0, 0, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 4, 0);
    ck("wb_clear_busy", 64'(rd_busy[0]), 64'h0);
    ck("wb_clear_cnt", 64'(busy_cnt), 64'h0);
    tick();
    cyc(1, 4, 32'h45, 4'hF, 1, 4, 0, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 4, 0);
    ck("set_wins", 64'(rd_busy[0]), 64'h1);
    tick();

    // Three issues, then a flush that swallows a same-cycle issue.
    cyc(1, 4, 32'h46, 4'h0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    ck("cnt3", 64'(busy_cnt), 64'h3);
    tick();
    cyc(0, 0, 0, 0, 1, 9, 1, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9, 4);
    ck("flush_cnt", 64'(busy_cnt), 64'h0);
    ck("flush_iss", 64'(rd_busy[0]), 64'h0);
    ck("be0_keeps", 64'(rd_data[63:32]), 64'h45);
    tick();

    // Asynchronous reset between edges, with a write and issue in flight.
    cyc(1, 10, 32'hCAFE, 4'hF, 1, 11, 0, 10, 11);
    step(1, 12, 32'h77, 4'hF, 1, 12, 0, 10, 11);
    #2 rst_n = 1'b0;
    #1;
    ck("async_data", 64'(rd_data), 64'h0);
    ck("async_busy", 64'(rd_busy), 64'h0);
    ck("async_cnt", 64'(busy_cnt), 64'h0);
    model_reset();
    tick();
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 12, 11);
    ck("rst_discard", 64'(rd_data), 64'h0);
    tick();

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] wa, ia, r0, r1;
      wa = (($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom));
      ia = (($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom));
      r0 = (($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7)));
      r1 = (($urandom_range(0, 2) == 0) ? ia : AW'($urandom));
      cyc(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom),
          ($urandom_range(0, 9) < 3), ia, ($urandom_range(0, 39) == 0), r0, r1);
    end

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
